// File: rtl/wb_bridge_pkg.sv
// Shared types and constants for the N-way Wishbone bridge.
package wb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_bridge_watchdog.sv
// Ack-wait watchdog: expires on the TIMEOUT_CYCLES-th consecutive enabled cycle.
module wb_bridge_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
        // The first wait cycle sees a count of 0, so the last allowed one sees TIMEOUT_CYCLES-1.
        expired_o = enable_i && (cnt_q == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_bridge_nway.sv
// Wishbone 1-to-N bridge: decodes a port from upper address bits, forwards the
// request, and returns the port's ack/data or an error word on decode error/timeout.
module wb_bridge_nway
    import wb_bridge_pkg::*;
#(
    parameter int          NUM_PORTS       = 4,
    parameter int          SEL_LSB         = 24,
    parameter int          SEL_WIDTH       = 3,
    parameter int          PORT_ADDR_WIDTH = 10,
    parameter int          TIMEOUT_CYCLES  = 255,
    parameter logic [31:0] ERR_DATA        = ERR_DATA_DEFAULT
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_we_i,
    input  logic [3:0]                 wbs_sel_i,
    input  logic [31:0]                wbs_dat_i,
    input  logic [31:0]                wbs_adr_i,
    output logic                       wbs_ack_o,
    output logic [31:0]                wbs_dat_o,
    output logic [NUM_PORTS-1:0]       wbm_stb_o,
    output logic [NUM_PORTS-1:0]       wbm_cyc_o,
    output logic                       wbm_we_o,
    output logic [3:0]                 wbm_sel_o,
    output logic [31:0]                wbm_dat_o,
    output logic [PORT_ADDR_WIDTH-1:0] wbm_adr_o,
    input  logic [NUM_PORTS-1:0]       wbm_ack_i,
    input  logic [32*NUM_PORTS-1:0]    wbm_dat_i,
    output logic [7:0]                 timeout_count_o,
    output logic                       decode_err_o
);

    state_e                     state_q, state_d;
    logic [NUM_PORTS-1:0]       port_q, port_d;
    logic                       we_q, we_d;
    logic [3:0]                 sel_q, sel_d;
    logic [31:0]                wdat_q, wdat_d;
    logic [PORT_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [31:0]                rdat_q, rdat_d;
    logic                       ack_q, ack_d;
    logic                       derr_q, derr_d;
    logic [7:0]                 tmo_q, tmo_d;

    logic [SEL_WIDTH-1:0] idx;
    logic [NUM_PORTS-1:0] dec_oh;
    logic                 dec_ok;
    logic                 sel_ack;
    logic [31:0]          sel_dat;
    logic                 wd_clear, wd_en, wd_expired;
    logic                 unused_adr;

    assign unused_adr = ^wbs_adr_i;

    // port_q is the registered one-hot of the selected port; masking with it ignores stray acks.
    always_comb begin
        idx     = wbs_adr_i[SEL_LSB +: SEL_WIDTH];
        dec_ok  = int'(idx) < NUM_PORTS;
        dec_oh  = '0;
        sel_dat = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (idx == SEL_WIDTH'(p)) dec_oh[p] = 1'b1;
            if (port_q[p]) sel_dat = sel_dat | wbm_dat_i[32*p +: 32];
        end
        sel_ack = |(wbm_ack_i & port_q);
    end

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        we_d     = we_q;
        sel_d    = sel_q;
        wdat_d   = wdat_q;
        adr_d    = adr_q;
        rdat_d   = rdat_q;
        ack_d    = 1'b0;
        derr_d   = 1'b0;
        tmo_d    = tmo_q;
        wd_clear = 1'b0;
        wd_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    we_d     = wbs_we_i;
                    sel_d    = wbs_sel_i;
                    wdat_d   = wbs_dat_i;
                    adr_d    = wbs_adr_i[PORT_ADDR_WIDTH-1:0];
                    wd_clear = 1'b1;
                    if (dec_ok) begin
                        port_d  = dec_oh;
                        state_d = ST_WAIT;
                    end else begin
                        rdat_d  = ERR_DATA;
                        ack_d   = 1'b1;
                        derr_d  = 1'b1;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                wd_en = 1'b1;
                // Abort beats ack, and ack beats timeout.
                if (!wbs_cyc_i) begin
                    port_d  = '0;
                    state_d = ST_IDLE;
                end else if (sel_ack) begin
                    rdat_d  = sel_dat;
                    port_d  = '0;
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end else if (wd_expired) begin
                    rdat_d  = ERR_DATA;
                    port_d  = '0;
                    ack_d   = 1'b1;
                    tmo_d   = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                port_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            port_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            adr_q   <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            derr_q  <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            adr_q   <= adr_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            derr_q  <= derr_d;
            tmo_q   <= tmo_d;
        end
    end

    wb_bridge_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_ni),
        .clear_i  (wd_clear),
        .enable_i (wd_en),
        .expired_o(wd_expired)
    );

    assign wbs_ack_o       = ack_q;
    assign wbs_dat_o       = rdat_q;
    assign wbm_stb_o       = port_q;
    assign wbm_cyc_o       = port_q;
    assign wbm_we_o        = we_q;
    assign wbm_sel_o       = sel_q;
    assign wbm_dat_o       = wdat_q;
    assign wbm_adr_o       = adr_q;
    assign timeout_count_o = tmo_q;
    assign decode_err_o    = derr_q;

endmodule

// File: tb/tb_wb_bridge_nway.sv
// Randomized bench for wb_bridge_nway against a transaction-level outcome model.
module tb_wb_bridge_nway;

    localparam int          NP  = 4;
    localparam int          T   = 8;
    localparam int          PAW = 10;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              wb_rst_ni;
    logic              wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_dat_i, wbs_adr_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;
    logic [NP-1:0]     wbm_stb_o, wbm_cyc_o;
    logic              wbm_we_o;
    logic [3:0]        wbm_sel_o;
    logic [31:0]       wbm_dat_o;
    logic [PAW-1:0]    wbm_adr_o;
    logic [NP-1:0]     wbm_ack_i;
    logic [32*NP-1:0]  wbm_dat_i;
    logic [7:0]        timeout_count_o;
    logic              decode_err_o;

    int n_tests = 0;
    int n_fail  = 0;
    int tmo_model = 0;

    always #5 clk = ~clk;

    wb_bridge_nway #(
        .NUM_PORTS(NP), .SEL_LSB(24), .SEL_WIDTH(3), .PORT_ADDR_WIDTH(PAW),
        .TIMEOUT_CYCLES(T), .ERR_DATA(ERR)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(wb_rst_ni),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o), .wbm_adr_o(wbm_adr_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
        .timeout_count_o(timeout_count_o), .decode_err_o(decode_err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One upstream transaction. d: cycles after the first downstream-strobe cycle at
    // which the selected port acks (-1 = never). abort_at/rst_at: cycle at which
    // cyc is dropped / reset is pulsed (-1 = not used). Cycle 0 is the request cycle.
    task automatic run_txn(input logic [31:0] adr, input logic we, input int d,
                           input logic [31:0] pdat, input int abort_at, input int rst_at);
        int          idx, exp_cyc, nack, nerr, ack_cyc;
        logic [NP-1:0] oh;
        logic [31:0] wdat, exp_dat, ack_dat;
        logic [3:0]  selv;
        bit          exp_err, exp_tmo, aborted;

        idx = int'(adr[26:24]);
        oh  = '0;
        if (idx < NP) oh[idx] = 1'b1;
        wdat = $urandom;
        selv = 4'($urandom_range(1, 15));

        // Outcome model: the port gets T wait cycles starting at cycle 1.
        aborted = (abort_at >= 0) || (rst_at >= 0);
        exp_err = 0; exp_tmo = 0;
        if (idx >= NP) begin
            exp_cyc = 1; exp_dat = ERR; exp_err = 1;
        end else if (d >= 0 && d + 1 <= T) begin
            exp_cyc = d + 2; exp_dat = pdat;
        end else begin
            exp_cyc = T + 1; exp_dat = ERR; exp_tmo = 1;
        end
        if (!aborted && exp_tmo && tmo_model < 255) tmo_model++;

        for (int p = 0; p < NP; p++) wbm_dat_i[32*p +: 32] = $urandom;
        if (idx < NP) wbm_dat_i[32*idx +: 32] = pdat;
        wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = wdat; wbs_sel_i = selv;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        nack = 0; nerr = 0; ack_cyc = -1; ack_dat = '0;

        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("stb_c1", 32'(wbm_stb_o), 32'(oh));
                check("cyc_c1", 32'(wbm_cyc_o), 32'(oh));
                if (we && idx < NP) begin
                    check("wr_we",  32'(wbm_we_o), 32'd1);
                    check("wr_adr", 32'(wbm_adr_o), 32'(adr[PAW-1:0]));
                    check("wr_dat", wbm_dat_o, wdat);
                    check("wr_sel", 32'(wbm_sel_o), 32'(selv));
                end
            end
            if (wbs_ack_o) begin
                nack++;
                if (ack_cyc < 0) begin ack_cyc = c; ack_dat = wbs_dat_o; end
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            end
            if (decode_err_o) nerr++;
            if (c == abort_at) begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; end
            if (abort_at >= 0 && c == abort_at + 1)
                check("abort_release", 32'(wbm_stb_o | wbm_cyc_o), 32'd0);
            if (c == rst_at) begin
                wb_rst_ni = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
                #1;
                check("rst_stb",  32'(wbm_stb_o | wbm_cyc_o), 32'd0);
                check("rst_ack",  32'(wbs_ack_o), 32'd0);
                check("rst_dat",  wbs_dat_o, 32'd0);
                check("rst_tmo",  32'(timeout_count_o), 32'd0);
                check("rst_wr",   {wbm_dat_o[31:5], wbm_we_o, wbm_sel_o}, 32'd0);
                tmo_model = 0;
            end
            if (rst_at >= 0 && c == rst_at + 1) wb_rst_ni = 1'b1;
            wbm_ack_i = ~oh & NP'($urandom | 32'h8);
            if (d >= 0 && c == d + 1) wbm_ack_i = wbm_ack_i | oh;
        end
        wbm_ack_i = '0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;

        if (aborted) begin
            check("no_ack", 32'(nack), 32'd0);
        end else begin
            check("ack_count", 32'(nack), 32'd1);
            check("ack_cycle", 32'(ack_cyc), 32'(exp_cyc));
            check("ack_data", ack_dat, exp_dat);
            check("derr_pulses", 32'(nerr), 32'(exp_err));
            check("dat_hold", wbs_dat_o, exp_dat);
        end
        check("tmo_count", 32'(timeout_count_o), 32'(tmo_model));
        check("released", 32'(wbm_stb_o | wbm_cyc_o), 32'd0);
    endtask

    initial begin
        wb_rst_ni = 1'b0;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = '0; wbs_dat_i = '0; wbs_adr_i = '0;
        wbm_ack_i = '0; wbm_dat_i = '0;
        repeat (2) @(negedge clk);
        check("reset_stb", 32'(wbm_stb_o | wbm_cyc_o), 32'd0);
        check("reset_ack", 32'(wbs_ack_o), 32'd0);
        check("reset_dat", wbs_dat_o, 32'd0);
        check("reset_tmo", 32'(timeout_count_o), 32'd0);
        check("reset_derr", 32'(decode_err_o), 32'd0);
        wb_rst_ni = 1'b1;
        @(negedge clk);

        run_txn(32'h0100_0004, 1'b0, 2,  32'h1234_5678, -1, -1);
        run_txn(32'h0300_0010, 1'b1, 1,  32'hCAFE_0003, -1, -1);
        run_txn(32'h0500_0000, 1'b0, -1, 32'h0,         -1, -1);
        run_txn(32'h0200_0000, 1'b0, -1, 32'h2222_2222, -1, -1);
        run_txn(32'h0000_0008, 1'b0, T-1, 32'hA5A5_0000, -1, -1);
        run_txn(32'h0000_000C, 1'b0, T,  32'hA5A5_0001, -1, -1);
        run_txn(32'h0100_0000, 1'b0, -1, 32'h0,         2,  -1);
        run_txn(32'h0100_0020, 1'b0, 0,  32'h0BAD_F00D, -1, -1);
        run_txn(32'h0200_0000, 1'b0, -1, 32'h0,         -1, 3);
        run_txn(32'h0000_0000, 1'b1, 3,  32'h7777_0000, -1, -1);

        for (int i = 0; i < 300; i++)
            run_txn(32'h0200_0000 | ($urandom & 32'h3FF), 1'($urandom), -1, $urandom, -1, -1);

        for (int i = 0; i < 150; i++) begin
            int dd;
            dd = int'($urandom_range(0, 10));
            if (dd == 10) dd = -1;
            run_txn({5'd0, 3'($urandom_range(0, 7)), 14'd0, 10'($urandom)},
                    1'($urandom), dd, $urandom, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
